dac_spi_out: RTL
================

DAC_SPI_OUT -- requirements
Module: dac_spi_out

Interface
REQ-001 Parameter CMD_BYTE, default 8'h30, command byte sent ahead of each 16-bit DAC data word.
REQ-002 clk_100M  input  1  system clock, 100 MHz, single clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sig_in  input  16  sample from the FM stage, offset binary (0x8000 = zero).
REQ-005 amp  input  8  unsigned gain, 128 = unity (gain = amp/128).
REQ-006 sample_div  input  16  sample period in clk_100M cycles; 0 disables sampling.
REQ-007 ovr_clr  input  1  single-cycle pulse that clears overrun.
REQ-008 dac_cs_n  output  1  DAC chip select, active low.
REQ-009 dac_sclk  output  1  serial clock, clk_100M/4 during a frame.
REQ-010 dac_din  output  1  serial data, MSB first.
REQ-011 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-012 sample_tick  output  1  registered one-cycle pulse at each sample instant.
REQ-013 overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-014 Divider counter: increments each cycle, wraps to 0 when count >= sample_div-1, and asserts sample_tick on the wrap cycle; with sample_div=0 the counter holds at 0 and sample_tick stays low.
REQ-015 A sample_div change takes effect at the next comparison with no restart; the period is exactly sample_div cycles when held constant.
REQ-016 Scaling: s = {~sig_in[15], sig_in[14:0]} signed; p = s * amp (24-bit signed); q = p >>> 7 (floor); saturate q to [-32768, 32767]; word = q with bit 15 inverted (offset binary).
REQ-017 In the cycle sample_tick=1 while in IDLE, shift register <= {CMD_BYTE, word} (24 bits), and the FSM goes to SETUP on the next edge.
REQ-018 FSM IDLE -> SETUP (2 cycles: cs_n=0, sclk=0, din=bit23) -> SHIFT (96 cycles) -> HOLD (2 cycles: cs_n=0, sclk=0) -> GAP (2 cycles: cs_n=1) -> IDLE; a frame is 102 cycles from the SETUP entry to the IDLE return.
REQ-019 In SHIFT, phase 0..95 gives bit = 23 - phase/4; din holds that bit for all 4 cycles; sclk=1 only when phase%4 is 2 or 3, giving 24 rising edges per frame.
REQ-020 Outside a frame: cs_n=1, sclk=0, din=0.
REQ-021 A sample_tick while busy=1 is dropped (no capture, frame unaffected) and sets overrun the next cycle.
REQ-022 ovr_clr clears overrun; if a set and a clear occur in the same cycle, the set wins.
REQ-023 sig_in and amp are sampled only in the capture cycle; changes mid-frame do not alter the frame in progress.

Reset
REQ-024 rst_n=0 asynchronously forces: FSM=IDLE, divider=0, shift register=0, dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, sample_tick=0, overrun=0.
REQ-025 Reset mid-frame aborts the frame immediately (no completion); after release, the first tick occurs sample_div cycles later.

Verification
REQ-026 amp=128, sig_in=0xC000, sample_div=200 -> frame 0x30C000 MSB first; cs_n low 100 cycles; 24 sclk rising edges; frame repeats every 200 cycles.
REQ-027 amp=255: sig_in=0xFFFF -> word 0xFFFF (positive saturation); sig_in=0x0000 -> word 0x0000 (negative saturation).
REQ-028 amp=64, sig_in=0x0000 -> word 0x4000; amp=0, any sig_in -> word 0x8000.
REQ-029 sample_div=50 -> frames start on ticks 0, 3, 6, ... (ticks 1 and 2 dropped during each 102-cycle frame); overrun=1 after tick 1; an ovr_clr pulse clears it; overrun re-sets on tick 4.
REQ-030 rst_n low during SHIFT bit 10 -> cs_n=1, sclk=0, din=0 in the same cycle; after release no frame starts before the next tick.
REQ-031 sample_div=0 for 1000 cycles -> no sample_tick, cs_n stays 1, busy stays 0.

Source files
------------

// File: rtl/dac_spi_out_if.sv
// rtl/dac_spi_out_if.sv - three-wire serial link to the DAC
interface dac_spi_out_if;
  logic dac_cs_n;
  logic dac_sclk;
  logic dac_din;

  modport master (output dac_cs_n, dac_sclk, dac_din);
  modport slave  (input  dac_cs_n, dac_sclk, dac_din);
endinterface

// File: rtl/dac_spi_out.sv
// rtl/dac_spi_out.sv - gain-scales FM samples and serializes them as 24-bit SPI DAC frames
module dac_spi_out #(
  parameter logic [7:0] CMD_BYTE = 8'h30
) (
  input  logic                 clk_100M,
  input  logic                 rst_n,
  input  logic [15:0]          sig_in,
  input  logic [7:0]           amp,
  input  logic [15:0]          sample_div,
  input  logic                 ovr_clr,
  dac_spi_out_if.master        spi,
  output logic                 busy,
  output logic                 sample_tick,
  output logic                 overrun
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state;
  logic [15:0]        div_cnt;
  logic [23:0]        shreg;
  logic [6:0]         phase;
  logic               cs_n_q;
  logic               sclk_q;
  logic               din_q;

  logic signed [24:0] s_ext;
  logic signed [24:0] a_ext;
  logic signed [24:0] prod;
  logic signed [24:0] q;
  logic [15:0]        q_sat;
  logic [15:0]        word;
  logic [6:0]         next_phase;
  logic [4:0]         next_bit;

  // Offset binary -> two's complement is just an MSB flip; the product always fits in 24 bits.
  always_comb begin
    s_ext = {{9{~sig_in[15]}}, ~sig_in[15], sig_in[14:0]};
    a_ext = {17'd0, amp};
    prod  = s_ext * a_ext;
    q     = prod >>> 7;
    if (q > 25'sd32767) begin
      q_sat = 16'h7FFF;
    end else if (q < -25'sd32768) begin
      q_sat = 16'h8000;
    end else begin
      q_sat = q[15:0];
    end
    word       = {~q_sat[15], q_sat[14:0]};
    next_phase = phase + 7'd1;
    next_bit   = 5'd23 - {1'b0, next_phase[6:3], next_phase[2]} + 5'd0;
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= 16'd0;
      sample_tick <= 1'b0;
    end else if (sample_div == 16'd0) begin
      div_cnt     <= 16'd0;
      sample_tick <= 1'b0;
    end else if (div_cnt >= sample_div - 16'd1) begin
      div_cnt     <= 16'd0;
      sample_tick <= 1'b1;
    end else begin
      div_cnt     <= div_cnt + 16'd1;
      sample_tick <= 1'b0;
    end
  end

  // Pin values are registered together with the state, so each assignment is for the next phase.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= 24'd0;
      phase  <= 7'd0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      din_q  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase  <= 7'd0;
          sclk_q <= 1'b0;
          if (sample_tick) begin
            shreg  <= {CMD_BYTE, word};
            state  <= SETUP;
            cs_n_q <= 1'b0;
            din_q  <= CMD_BYTE[7];
            busy   <= 1'b1;
          end else begin
            cs_n_q <= 1'b1;
            din_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (phase[0]) begin
            state  <= SHIFT;
            phase  <= 7'd0;
            sclk_q <= 1'b0;
            din_q  <= shreg[23];
          end else begin
            phase  <= next_phase;
          end
        end
        SHIFT: begin
          if (phase == 7'd95) begin
            state  <= HOLD;
            phase  <= 7'd0;
            sclk_q <= 1'b0;
            din_q  <= 1'b0;
          end else begin
            phase  <= next_phase;
            sclk_q <= next_phase[1];
            din_q  <= shreg[next_bit];
          end
        end
        HOLD: begin
          if (phase[0]) begin
            state  <= GAP;
            phase  <= 7'd0;
            cs_n_q <= 1'b1;
          end else begin
            phase  <= next_phase;
          end
        end
        GAP: begin
          if (phase[0]) begin
            state <= IDLE;
            phase <= 7'd0;
            busy  <= 1'b0;
          end else begin
            phase <= next_phase;
          end
        end
        default: begin
          state  <= IDLE;
          phase  <= 7'd0;
          cs_n_q <= 1'b1;
          sclk_q <= 1'b0;
          din_q  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (sample_tick && busy) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign spi.dac_cs_n = cs_n_q;
  assign spi.dac_sclk = sclk_q;
  assign spi.dac_din  = din_q;

endmodule
